// File: rtl/uart_datamemload.sv
// rtl/uart_datamemload.sv - UART receiver that packs bytes into 32-bit words and writes them to a data memory
//
// Receives 8N1 frames on RX, or 8E1 frames when UART_DATAMEMLOAD_PARITY_EN is defined.
// Accepted bytes are assembled little-endian into 32-bit words. Each complete word is
// written to consecutive word addresses, and the address wraps after 2**ADDR_W words.
//
// Ports:
//   CLK        sole clock, rising edge
//   nrst       asynchronous active-low reset
//   RX         UART serial input, idles high, asynchronous to CLK
//   con_write  byte-write enables, 4'hF for one cycle per completed word, else 4'h0
//   con_addr   word address of the last write (held between writes)
//   con_in     data of the last write (held between writes)
//   busy       receiving a frame, or a word is partially assembled
//   load_done  one-cycle pulse together with the write to the last address
//   frame_err  sticky: bad stop bit (or bad parity); cleared only by reset
module uart_datamemload #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              RX,
  output logic [3:0]        con_write,
  output logic [ADDR_W-1:0] con_addr,
  output logic [31:0]       con_in,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);

`ifdef UART_DATAMEMLOAD_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        con_write_q, con_write_d;
  logic [ADDR_W-1:0] con_addr_q, con_addr_d;
  logic [31:0]       con_in_q, con_in_d;
  logic              load_done_q, load_done_d;
  logic              frame_err_q, frame_err_d;
  logic              stop_wait_q, stop_wait_d;
`ifdef UART_DATAMEMLOAD_PARITY_EN
  logic              par_err_q, par_err_d;
`endif
  logic              accept;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      ptr_q       <= '0;
      con_write_q <= '0;
      con_addr_q  <= '0;
      con_in_q    <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      stop_wait_q <= 1'b0;
`ifdef UART_DATAMEMLOAD_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      ptr_q       <= ptr_d;
      con_write_q <= con_write_d;
      con_addr_q  <= con_addr_d;
      con_in_q    <= con_in_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      stop_wait_q <= stop_wait_d;
`ifdef UART_DATAMEMLOAD_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = RX;
    rx_sync_d   = rx_meta_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    ptr_d       = ptr_q;
    con_write_d = 4'h0;
    con_addr_d  = con_addr_q;
    con_in_d    = con_in_q;
    load_done_d = 1'b0;
    frame_err_d = frame_err_q;
    stop_wait_d = stop_wait_q;
`ifdef UART_DATAMEMLOAD_PARITY_EN
    par_err_d   = par_err_q;
`endif
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_cnt_d  = '0;
        bit_cnt_d   = '0;
        stop_wait_d = 1'b0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        // Resample at the start-bit midpoint; a high line here was only a glitch.
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          state_d    = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_DATAMEMLOAD_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_DATAMEMLOAD_PARITY_EN
      S_PARITY: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_err_d  = (^shift_q) ^ rx_sync_q;
          if ((^shift_q) ^ rx_sync_q) frame_err_d = 1'b1;
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (stop_wait_q) begin
          // Broken frame: hold off until the line is idle again.
          if (rx_sync_q) begin
            stop_wait_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          if (rx_sync_q) begin
            state_d = S_IDLE;
`ifdef UART_DATAMEMLOAD_PARITY_EN
            accept  = !par_err_q;
`else
            accept  = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      word_d = word_q;
      word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
      if (byte_idx_q == 2'd3) begin
        con_write_d = 4'hF;
        con_addr_d  = ptr_q;
        con_in_d    = word_d;
        load_done_d = (ptr_q == {ADDR_W{1'b1}});
        ptr_d       = ptr_q + ADDR_W'(1);
        byte_idx_d  = 2'd0;
      end else begin
        byte_idx_d  = byte_idx_q + 2'd1;
      end
    end
  end

  assign con_write = con_write_q;
  assign con_addr  = con_addr_q;
  assign con_in    = con_in_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE) || (byte_idx_q != 2'd0);

endmodule

// File: tb/tb_uart_datamemload.sv
// tb/tb_uart_datamemload.sv - scoreboard bench for uart_datamemload
module tb_uart_datamemload;

  localparam int A_CLK = 50000000;
  localparam int A_BAUD = 115200;
  localparam int A_CPB = A_CLK / A_BAUD;
  localparam int B_CLK = 1000000;
  localparam int B_BAUD = 58000;
  localparam int B_CPB = B_CLK / B_BAUD;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        nrst_a, rx_a, busy_a, ld_a, ferr_a;
  logic [3:0]  we_a;
  logic [9:0]  addr_a;
  logic [31:0] din_a;
  logic        nrst_b, rx_b, busy_b, ld_b, ferr_b;
  logic [3:0]  we_b;
  logic [1:0]  addr_b;
  logic [31:0] din_b;

  uart_datamemload #(.CLK_FREQ(A_CLK), .BAUD(A_BAUD), .ADDR_W(10)) dut_a (
    .CLK(clk), .nrst(nrst_a), .RX(rx_a), .con_write(we_a), .con_addr(addr_a),
    .con_in(din_a), .busy(busy_a), .load_done(ld_a), .frame_err(ferr_a));

  uart_datamemload #(.CLK_FREQ(B_CLK), .BAUD(B_BAUD), .ADDR_W(2)) dut_b (
    .CLK(clk), .nrst(nrst_b), .RX(rx_b), .con_write(we_b), .con_addr(addr_b),
    .con_in(din_b), .busy(busy_b), .load_done(ld_b), .frame_err(ferr_b));

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          ld;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int          n_checks = 0;
  int          n_pass = 0;
  int          m_idx[2];
  logic [31:0] m_word[2];
  int          m_ptr[2];
  bit          m_ferr[2];
  int          depth[2];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endfunction

  // Reference model: a word is four good bytes in arrival order, written to the next slot.
  function automatic void model_byte(int s, logic [7:0] d, bit good);
    exp_t e;
    if (!good) begin
      m_ferr[s] = 1'b1;
      return;
    end
    m_word[s] = m_word[s] | (32'(d) << (8 * m_idx[s]));
    m_idx[s]++;
    if (m_idx[s] == 4) begin
      e.addr = m_ptr[s];
      e.data = m_word[s];
      e.ld   = (m_ptr[s] == depth[s] - 1);
      if (s == 0) qa.push_back(e);
      else qb.push_back(e);
      m_ptr[s]  = (m_ptr[s] + 1) % depth[s];
      m_idx[s]  = 0;
      m_word[s] = 32'h0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (we_a != 4'h0) begin
      check("a_we_value", we_a, 4'hF);
      check("a_write_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_addr", addr_a, e.addr);
        check("a_data", din_a, e.data);
        check("a_load_done", ld_a, e.ld);
      end
    end else if (ld_a) begin
      check("a_load_done_without_write", ld_a, 0);
    end
    if (we_b != 4'h0) begin
      check("b_we_value", we_b, 4'hF);
      check("b_write_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_addr", addr_b, e.addr);
        check("b_data", din_b, e.data);
        check("b_load_done", ld_b, e.ld);
      end
    end else if (ld_b) begin
      check("b_load_done_without_write", ld_b, 0);
    end
  end

  task automatic set_rx(int s, logic v);
    if (s == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic bit_wait(int s);
    repeat ((s == 0) ? A_CPB : B_CPB) @(negedge clk);
  endtask

  task automatic send_byte(int s, logic [7:0] d, logic stop_bit, logic par_bit, int gap);
    bit good;
    good = stop_bit;
`ifdef UART_DATAMEMLOAD_PARITY_EN
    if (par_bit != ^d) good = 1'b0;
`endif
    model_byte(s, d, good);
    @(negedge clk);
    set_rx(s, 1'b0);
    bit_wait(s);
    for (int i = 0; i < 8; i++) begin
      set_rx(s, d[i]);
      bit_wait(s);
    end
`ifdef UART_DATAMEMLOAD_PARITY_EN
    set_rx(s, par_bit);
    bit_wait(s);
`endif
    set_rx(s, stop_bit);
    bit_wait(s);
    set_rx(s, 1'b1);
    if (!stop_bit) bit_wait(s);
    repeat (gap) @(negedge clk);
  endtask

  task automatic good_byte(int s, logic [7:0] d, int gap);
    send_byte(s, d, 1'b1, ^d, gap);
  endtask

  task automatic do_reset(int s);
    @(negedge clk);
    if (s == 0) nrst_a = 1'b0;
    else nrst_b = 1'b0;
    #3;
    if (s == 0) begin
      check("a_rst_we", we_a, 0);
      check("a_rst_addr", addr_a, 0);
      check("a_rst_data", din_a, 0);
      check("a_rst_busy", busy_a, 0);
      check("a_rst_ld", ld_a, 0);
      check("a_rst_ferr", ferr_a, 0);
    end else begin
      check("b_rst_we", we_b, 0);
      check("b_rst_addr", addr_b, 0);
      check("b_rst_data", din_b, 0);
      check("b_rst_busy", busy_b, 0);
      check("b_rst_ld", ld_b, 0);
      check("b_rst_ferr", ferr_b, 0);
    end
    m_idx[s] = 0;
    m_word[s] = 32'h0;
    m_ptr[s] = 0;
    m_ferr[s] = 1'b0;
    repeat (3) @(negedge clk);
    if (s == 0) nrst_a = 1'b1;
    else nrst_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(int s, string name);
    int n = 0;
    while (((s == 0) ? qa.size() : qb.size()) != 0 && n < 30 * ((s == 0) ? A_CPB : B_CPB)) begin
      @(negedge clk);
      n++;
    end
    check(name, (s == 0) ? qa.size() : qb.size(), 0);
  endtask

  initial begin
    depth[0] = 1024;
    depth[1] = 4;
    rx_a = 1'b1;
    rx_b = 1'b1;
    nrst_a = 1'b0;
    nrst_b = 1'b0;
    #45;
    do_reset(0);
    do_reset(1);

    // Default-rate word
    good_byte(0, 8'h78, 0);
    good_byte(0, 8'h56, 0);
    check("a_busy_mid_word", busy_a, 1);
    good_byte(0, 8'h34, 0);
    good_byte(0, 8'h12, A_CPB);
    wait_drain(0, "a_word0_drain");
    check("a_busy_after_word", busy_a, 0);
    check("a_ferr_after_word", ferr_a, 0);

    // Short low glitch while idle
    @(negedge clk);
    rx_a = 1'b0;
    #200;
    rx_a = 1'b1;
    repeat (A_CPB) @(negedge clk);
    check("a_glitch_busy", busy_a, 0);
    check("a_glitch_ferr", ferr_a, 0);

    // Two words back to back
    do_reset(1);
    for (int i = 0; i < 8; i++) good_byte(1, 8'(8'h10 + i), 0);
    wait_drain(1, "b_two_words_drain");

    // Bad stop bit then a clean word
    do_reset(1);
    send_byte(1, 8'hAA, 1'b0, 1'b0, B_CPB);
    check("b_ferr_after_bad_stop", ferr_b, 1);
    good_byte(1, 8'h01, 0);
    good_byte(1, 8'h02, 0);
    good_byte(1, 8'h03, 0);
    good_byte(1, 8'h04, B_CPB);
    wait_drain(1, "b_ferr_word_drain");
    check("b_ferr_sticky", ferr_b, 1);

    // Wrap-around with load_done, then overwrite from address 0
    do_reset(1);
    for (int i = 0; i < 20; i++) good_byte(1, 8'($urandom), 0);
    wait_drain(1, "b_wrap_drain");

    // Reset mid-word discards partial data
    do_reset(1);
    good_byte(1, 8'hDE, 0);
    good_byte(1, 8'hAD, B_CPB);
    do_reset(1);
    for (int i = 0; i < 4; i++) good_byte(1, 8'(8'hC0 + i), 0);
    wait_drain(1, "b_after_reset_drain");

`ifdef UART_DATAMEMLOAD_PARITY_EN
    do_reset(1);
    send_byte(1, 8'h03, 1'b1, 1'b1, B_CPB);
    check("b_parity_err_ferr", ferr_b, 1);
    check("b_parity_err_busy", busy_b, 0);
    send_byte(1, 8'h03, 1'b1, 1'b0, 0);
    check("b_parity_ok_busy", busy_b, 1);
    for (int i = 0; i < 3; i++) good_byte(1, 8'(8'h50 + i), 0);
    wait_drain(1, "b_parity_drain");
`endif

    // Randomized traffic with occasional broken frames
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       st;
      logic       pb;
      d  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = ^d;
`ifdef UART_DATAMEMLOAD_PARITY_EN
      if ($urandom_range(0, 7) == 0) pb = ~pb;
`endif
      send_byte(1, d, st, pb, $urandom_range(0, 2 * B_CPB));
    end
    wait_drain(1, "b_random_drain");
    check("b_random_ferr", ferr_b, m_ferr[1]);
    check("b_random_busy", busy_b, m_idx[1] != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
